// File: rtl/io_pkg.sv
// io_pkg: shared IO-side constants for the seven-segment controller.
package io_pkg;
    typedef enum logic [1:0] {
        SEG7_OFF_DATA   = 2'd0,
        SEG7_OFF_CTRL   = 2'd1,
        SEG7_OFF_STATUS = 2'd2,
        SEG7_OFF_RSVD   = 2'd3
    } seg7_reg_e;
    localparam logic [7:0] SEG7_BLANK = 8'hFF;
    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG7_HEX7 = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import io_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG7_HEX7[nib];
endmodule

// File: rtl/io_seg7_ctrl.sv
// io_seg7_ctrl: memory-mapped 8-digit multiplexed seven-segment controller.
module io_seg7_ctrl
    import io_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic        ioWrite,
    input  logic        ioRead,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);
    localparam int PW = $clog2(SCAN_DIV);
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    mask_q, mask_d, dp_q, dp_d, en_q, en_d, seg_q, seg_d;
    logic [6:0]    hex;
    logic          tick, wr;
    seg7_reg_e     sel;
    assign sel  = seg7_reg_e'(addr[3:2]);
    assign wr   = cs & ioWrite;
    assign tick = pre_q == PW'(SCAN_DIV - 1);
    seg7_hex_decode u_dec (.nib(data_q[{idx_d, 2'b00} +: 4]), .seg(hex));
    // Output register samples pre-write DATA/CTRL at the new scan index.
    always_comb begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        idx_d  = tick ? idx_q + 3'd1 : idx_q;
        data_d = (wr && sel == SEG7_OFF_DATA) ? wdata : data_q;
        mask_d = (wr && sel == SEG7_OFF_CTRL) ? wdata[7:0] : mask_q;
        dp_d   = (wr && sel == SEG7_OFF_CTRL) ? wdata[15:8] : dp_q;
        en_d   = !tick ? en_q : mask_q[idx_d] ? ~(8'b1 << idx_d) : SEG7_BLANK;
        seg_d  = !tick ? seg_q : mask_q[idx_d] ? {~dp_q[idx_d], hex} : SEG7_BLANK;
        rdata  = !(cs && ioRead)       ? 32'h0 :
                 sel == SEG7_OFF_DATA   ? data_q :
                 sel == SEG7_OFF_CTRL   ? {16'h0, dp_q, mask_q} :
                 sel == SEG7_OFF_STATUS ? {29'h0, idx_q} : 32'h0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            mask_q <= 8'hFF;
            dp_q   <= '0;
            en_q   <= SEG7_BLANK;
            seg_q  <= SEG7_BLANK;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            mask_q <= mask_d;
            dp_q   <= dp_d;
            en_q   <= en_d;
            seg_q  <= seg_d;
        end
    end
    assign seg_en  = en_q;
    assign seg_out = seg_q;
endmodule

// File: tb/tb_io_seg7_ctrl.sv
// tb_io_seg7_ctrl: directed bench with a cycle-count reference model of the display.
module tb_io_seg7_ctrl;
    localparam int SD = 4;
    logic clock = 0, reset = 1, cs = 0, ioWrite = 0, ioRead = 0;
    logic [3:0] addr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [7:0] seg_en, seg_out;
    int total = 0, bad = 0;

    io_seg7_ctrl #(.SCAN_DIV(SD)) dut (
        .clock(clock), .reset(reset), .cs(cs), .ioWrite(ioWrite), .ioRead(ioRead),
        .addr(addr), .wdata(wdata), .rdata(rdata), .seg_en(seg_en), .seg_out(seg_out)
    );

    always #5 clock = ~clock;

    logic [6:0] hx [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] md;
    logic [7:0] mm, mdp, men, mseg;
    int mcyc, nk;
    assign nk = ((mcyc + 1) / SD) % 8;

    // Model: digit shown is a pure function of edges since reset.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            md <= 0; mm <= 8'hFF; mdp <= 0; men <= 8'hFF; mseg <= 8'hFF; mcyc <= 0;
        end else begin
            mcyc <= mcyc + 1;
            if (mcyc % SD == SD - 1) begin
                men  <= mm[nk] ? ~(8'd1 << nk) : 8'hFF;
                mseg <= mm[nk] ? {~mdp[nk], hx[md[4*nk +: 4]]} : 8'hFF;
            end
            if (cs && ioWrite && addr[3:2] == 2'd0) md <= wdata;
            if (cs && ioWrite && addr[3:2] == 2'd1) begin mm <= wdata[7:0]; mdp <= wdata[15:8]; end
        end
    end

    function automatic logic [31:0] mrd();
        if (!(cs && ioRead)) return 0;
        case (addr[3:2])
            2'd0: return md;
            2'd1: return {16'h0, mdp, mm};
            2'd2: return 32'((mcyc / SD) % 8);
            default: return 0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) if ($time > 8) begin
        chk("model seg_en", {24'h0, seg_en}, {24'h0, men});
        chk("model seg_out", {24'h0, seg_out}, {24'h0, mseg});
        chk("model rdata", rdata, mrd());
    end

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic align(int t);
        for (int i = 0; i < 64 && mcyc % 32 != t; i++) step(1);
    endtask
    task automatic wr(logic [3:0] a, logic [31:0] d);
        cs = 1; ioWrite = 1; addr = a; wdata = d;
        step(1);
        cs = 0; ioWrite = 0;
    endtask
    task automatic rd(string nm, logic [3:0] a, logic [31:0] exp, logic c = 1);
        cs = c; ioRead = 1; addr = a;
        #1 chk(nm, rdata, exp);
        step(1);
        cs = 0; ioRead = 0;
    endtask
    task automatic out(string nm, logic [7:0] e, logic [7:0] s);
        chk({nm, " en"}, {24'h0, seg_en}, {24'h0, e});
        chk({nm, " seg"}, {24'h0, seg_out}, {24'h0, s});
    endtask

    logic [7:0] e2 [8] = '{8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [7:0] s2 [8] = '{8'h99, 8'h92, 8'h82, 8'hF8, 8'hC0, 8'hF9, 8'hA4, 8'hB0};

    initial begin
        step(2);
        reset = 0;
        out("reset", 8'hFF, 8'hFF);
        step(3);
        out("pre-tick", 8'hFF, 8'hFF);
        step(1);
        out("first tick", 8'hFD, 8'hC0);
        step(8);
        wr(4'h0, 32'h7654_3210);
        wr(4'h4, 32'h0000_00FF);
        for (int j = 0; j < 8; j++) begin
            align((16 + 4 * j) % 32);
            out("scan", e2[j], s2[j]);
        end
        wr(4'h4, 32'h0100_0005);
        rd("ctrl hi dropped", 4'h4, 32'h0000_0005);
        align(16); out("masked d4", 8'hFF, 8'hFF);
        align(0);  out("d0 dp off", 8'hFE, 8'hC0);
        align(8);  out("d2", 8'hFB, 8'hA4);
        wr(4'h4, 32'h0000_0105);
        align(0);  out("d0 dp on", 8'hFE, 8'h40);
        rd("data", 4'h0, 32'h7654_3210);
        rd("ctrl", 4'h4, 32'h0000_0105);
        rd("off3", 4'hC, 32'h0);
        rd("cs0", 4'h0, 32'h0, 1'b0);
        wr(4'h8, 32'hFFFF_FFFF);
        wr(4'hC, 32'hFFFF_FFFF);
        align(4);
        rd("status", 4'h8, 32'h1);
        rd("data kept", 4'h0, 32'h7654_3210);
        cs = 1; ioWrite = 1; ioRead = 1; addr = 4'h0; wdata = 32'h89AB_CDEF;
        #1 chk("rw old", rdata, 32'h7654_3210);
        step(1);
        cs = 0; ioWrite = 0; ioRead = 0;
        rd("rw new", 4'h0, 32'h89AB_CDEF);
        wr(4'h4, 32'h0000_FFFF);
        rd("ctrl dp", 4'h4, 32'h0000_FFFF);
        align(7);
        wr(4'h0, 32'hFFFF_FFFF);
        out("tick write old", 8'hFB, 8'h21);
        step(4);
        out("tick write new", 8'hF7, 8'h0E);
        align(22);
        out("pre reset", 8'hDF, 8'h0E);
        cs = 1; ioRead = 1; addr = 4'h8;
        #1 chk("status 5", rdata, 32'h5);
        reset = 1;
        #1 out("async reset", 8'hFF, 8'hFF);
        chk("status rst", rdata, 32'h0);
        addr = 4'h4;
        #1 chk("ctrl rst", rdata, 32'h0000_00FF);
        addr = 4'h0;
        #1 chk("data rst", rdata, 32'h0);
        cs = 0; ioRead = 0;
        step(1);
        reset = 0;
        step(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
